// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes a MIPS instruction into ALU controls and operands,
// holds them behind a valid/ready handshake with stall and flush, and counts fired transfers.
module alu_issue_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            inst,
  input  logic [DATA_WIDTH-1:0]  rs_value,
  input  logic [DATA_WIDTH-1:0]  rt_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [3:0]             alu_op,
  output logic [DATA_WIDTH-1:0]  alu_a,
  output logic [DATA_WIDTH-1:0]  alu_b,
  output logic [4:0]             dest_reg,
  output logic                   reg_wen,
  output logic                   ov_trap_en,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] issue_count
);

  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_OR   = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_SLT  = 4'h4,
    OP_SLTU = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_SAL  = 4'h8,
    OP_SRA  = 4'h9,
    OP_LUI  = 4'hA,
    OP_XOR  = 4'hB,
    OP_NOR  = 4'hC
  } alu_op_e;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opcode = inst[31:26];
  assign rt_idx = inst[20:16];
  assign rd_idx = inst[15:11];
  assign shamt  = inst[10:6];
  assign funct  = inst[5:0];
  assign imm    = inst[15:0];

  // The rs index is resolved upstream; rs_value already carries the forwarded operand.
  logic unused_rs_idx;
  assign unused_rs_idx = ^inst[25:21];

  logic [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0] imm_zext;
  logic [DATA_WIDTH-1:0] shamt_zext;

  assign imm_sext   = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign imm_zext   = {{(DATA_WIDTH-16){1'b0}}, imm};
  assign shamt_zext = {{(DATA_WIDTH-5){1'b0}}, shamt};

  // Decoded (combinational) view of the incoming instruction
  alu_op_e               dec_op;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b;
  logic [4:0]            dec_dest;
  logic                  dec_wen;
  logic                  dec_trap;
  logic                  dec_illegal;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    dec_op      = OP_AND;
    dec_a       = rs_value;
    dec_b       = rt_value;
    dec_dest    = rt_idx;
    dec_wen     = 1'b1;
    dec_trap    = 1'b0;
    dec_illegal = 1'b0;

    case (opcode)
      6'h00: begin
        dec_dest = rd_idx;
        case (funct)
          6'h20: begin dec_op = OP_ADD; dec_trap = 1'b1; end
          6'h21: dec_op = OP_ADD;
          6'h22: begin dec_op = OP_SUB; dec_trap = 1'b1; end
          6'h23: dec_op = OP_SUB;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h26: dec_op = OP_XOR;
          6'h27: dec_op = OP_NOR;
          6'h2A: dec_op = OP_SLT;
          6'h2B: dec_op = OP_SLTU;
          6'h00: begin dec_op = OP_SLL; dec_a = shamt_zext; end
          6'h02: begin dec_op = OP_SRL; dec_a = shamt_zext; end
          6'h03: begin dec_op = OP_SRA; dec_a = shamt_zext; end
          6'h04: dec_op = OP_SLL;
          6'h06: dec_op = OP_SRL;
          6'h07: dec_op = OP_SRA;
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h08: begin dec_op = OP_ADD;  dec_b = imm_sext; dec_trap = 1'b1; end
      6'h09: begin dec_op = OP_ADD;  dec_b = imm_sext; end
      6'h0A: begin dec_op = OP_SLT;  dec_b = imm_sext; end
      6'h0B: begin dec_op = OP_SLTU; dec_b = imm_sext; end
      6'h0C: begin dec_op = OP_AND;  dec_b = imm_zext; end
      6'h0D: begin dec_op = OP_OR;   dec_b = imm_zext; end
      6'h0E: begin dec_op = OP_XOR;  dec_b = imm_zext; end
      6'h0F: begin dec_op = OP_LUI;  dec_b = imm_zext; end
      6'h23: begin dec_op = OP_ADD;  dec_b = imm_sext; end
      6'h2B: begin dec_op = OP_ADD;  dec_b = imm_sext; dec_wen = 1'b0; end
      default: dec_illegal = 1'b1;
    endcase

    // Illegal entries still flow down the pipe but must have no side effects in EX.
    if (dec_illegal) begin
      dec_op   = OP_AND;
      dec_wen  = 1'b0;
      dec_trap = 1'b0;
    end
    if (dec_dest == 5'd0) dec_wen = 1'b0;
  end

  // Handshake
  logic valid_q;
  logic accept;
  logic fire;

  assign in_ready  = ~flush & (~valid_q | out_ready);
  assign out_valid = valid_q & ~flush;
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  alu_op_e               op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [4:0]            dest_q;
  logic                  wen_q;
  logic                  trap_q;
  logic                  illegal_q;
  logic [COUNT_WIDTH-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values. The data registers are reset too, because the stage must
  // present all-zero outputs during reset rather than stale operands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      op_q      <= OP_AND;
      a_q       <= '0;
      b_q       <= '0;
      dest_q    <= '0;
      wen_q     <= 1'b0;
      trap_q    <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (accept) begin
        valid_q   <= 1'b1;
        op_q      <= dec_op;
        a_q       <= dec_a;
        b_q       <= dec_b;
        dest_q    <= dec_dest;
        wen_q     <= dec_wen;
        trap_q    <= dec_trap;
        illegal_q <= dec_illegal;
      end else if (out_ready || flush) begin
        valid_q <= 1'b0;
      end

      if (fire) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign dest_reg    = dest_q;
  assign reg_wen     = wen_q;
  assign ov_trap_en  = trap_q;
  assign illegal     = illegal_q;
  assign issue_count = count_q;

endmodule
